gclk_change_checker: RTL and testbench
======================================

# gclk_change_checker

Synthesizable run-time checker that enforces "a change on `sig` must be answered by a falling edge on `resp` within a bounded window". It is the hardware counterpart of the global-clocking sampled-value assertions in the assertion suite. Past and future sampled values are rebuilt from one-cycle history registers, and an attempt/window FSM sequences each check. It sits beside the observed datapath on the global clock domain and reports pass/fail pulses plus a saturating failure count.

## Interface
- `WINDOW`, default 4: number of clock edges after the attempt edge in which `resp` may fall. Legal range 0..255. 0 means the fall must coincide with the change (overlapping implication).
- `CNT_W`, default 8: width of the failure counter.

- `clk`  in  1  global clock; all sampling on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  checker enable.
- `sig`  in  1  monitored signal.
- `resp`  in  1  response signal; its falling edge satisfies a pending check.
- `clr`  in  1  clears `fail_cnt` and, when compiled in, the sticky flag.
- `busy`  out  1  high while in WAIT.
- `pass`  out  1  one-cycle pulse: check satisfied.
- `fail`  out  1  check violated (pulse, or sticky; see Configuration).
- `fail_cnt`  out  CNT_W  saturating count of failures.

## Operation
- History registers `sig_q` and `resp_q` capture `sig` and `resp` on every edge.
- Valid bit `v` goes to 0 on reset and to 1 on the first edge after reset. While `v`=0, detection is masked.
- At edge n, with `v`=1:
  - `chg` = `sig_q` XOR `sig`.
  - `fall` = `resp_q` AND NOT `resp`.
  - Both are future-value functions of the attempt at edge n-1, evaluated at n.
- FSM states: IDLE, WAIT. Down-counter `cnt` is 8 bits wide.
- IDLE:
  - `en` and `chg` and `fall`: assert `pass`, stay in IDLE.
  - `en` and `chg` and not `fall`:
    - If `WINDOW`=0: assert `fail`, stay in IDLE.
    - Otherwise: load `cnt`=`WINDOW` and go to WAIT.
  - Otherwise: stay in IDLE.
- WAIT:
  - `en`=0: abort to IDLE with no verdict.
  - `fall`: assert `pass`, go to IDLE.
  - `cnt`=1: assert `fail`, go to IDLE.
  - Otherwise: decrement `cnt`.
- A change seen while in WAIT does not start a new attempt and does not restart the window. A `fall` in the same cycle as such a change satisfies the pending attempt only.
- On every `fail` assertion, `fail_cnt` increments and saturates at 2^CNT_W-1.
- `clr` zeroes `fail_cnt`. If `clr` and an increment occur in the same edge, `clr` wins and the result is 0.
- `clr` does not affect the FSM.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, `v`=0, `sig_q`=0, `resp_q`=0, `busy`=0, `pass`=0, `fail`=0, `fail_cnt`=0.
- Reset asserted mid-WAIT returns to IDLE at that edge with no verdict. The first edge after reset release cannot detect anything because `v`=0.
- All outputs are registered:
  - A decision at edge n is visible from edge n until edge n+1.
  - `busy` rises at the edge that enters WAIT.
- Worst-case latency from the attempt edge to a verdict is `WINDOW`+1 edges.
- Back-to-back attempts: a verdict and a new attempt can occur at the same edge only from IDLE. A change at the edge that leaves WAIT is ignored.

## Configuration
- `GCLK_CHK_STICKY_EN` defined:
  - `fail` is set at the first failure.
  - It holds high until `clr` or `rst`.
  - If `clr` and a new failure occur in the same edge, `fail` stays 1.
- Not defined: `fail` is a one-cycle pulse per failure.
- `fail_cnt` behaves identically in both builds.

## Test plan
- Reset, then `en`=1 and `sig` toggles 0→1 sampled at edge 5 with `resp` steady 1, falling at edge 7 (`WINDOW`=4) -> `busy`=1 after edge 5; `pass`=1 after edge 7; `fail_cnt`=0.
- `WINDOW`=4, `sig` toggles at edge 5 and `resp` never falls -> `fail`=1 after edge 9; `fail_cnt`=1; `busy`=0 after edge 9.
- `WINDOW`=0, `sig` change and `resp` fall both at edge 5 -> `pass` after edge 5. Change alone at edge 8 -> `fail` after edge 8, `fail_cnt`=1.
- `CNT_W`=2, five forced failures -> `fail_cnt` saturates at 3. Then `clr` coinciding with a sixth failure -> `fail_cnt`=0. With `GCLK_CHK_STICKY_EN`, `fail` remains 1.
- `sig` toggles at edge 5, `en` drops at edge 6 -> FSM returns to IDLE, no `pass` or `fail`, `fail_cnt` unchanged.
- `sig` toggles at edge 5, `rst` pulsed at edge 6 -> all outputs 0. A `sig` toggle at the first edge after `rst` release is ignored (`v`=0).

Source files
------------

// File: rtl/gclk_change_checker.sv
// Run-time checker: a change on sig must be answered by a falling edge on resp within WINDOW edges.
// Define GCLK_CHK_STICKY_EN to make fail a sticky flag (held until clr or rst) instead of a pulse.
module gclk_change_checker #(
  parameter int unsigned WINDOW = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig,
  input  logic             resp,
  input  logic             clr,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0]       WIN8     = 8'(WINDOW);
  localparam bit               ZERO_WIN = (WINDOW == 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       v;
  logic       sig_q, resp_q;
  logic       chg, fall;
  logic       pass_nx, fail_nx;
  logic       fail_evt;

  // Future-value view of the previous edge's attempt, masked until history is valid
  assign chg  = v & (sig_q ^ sig);
  assign fall = v & resp_q & ~resp;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pass_nx  = 1'b0;
    fail_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (en && chg) begin
          if (fall) begin
            pass_nx = 1'b1;
          end else if (ZERO_WIN) begin
            fail_nx = 1'b1;
          end else begin
            cnt_nx   = WIN8;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        // Changes seen here never start or restart an attempt
        if (!en) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (fall) begin
          pass_nx  = 1'b1;
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (cnt == 8'd1) begin
          fail_nx  = 1'b1;
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      v        <= 1'b0;
      sig_q    <= 1'b0;
      resp_q   <= 1'b0;
      busy     <= 1'b0;
      pass     <= 1'b0;
      fail_evt <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      v        <= 1'b1;
      sig_q    <= sig;
      resp_q   <= resp;
      busy     <= (state_nx == WAIT);
      pass     <= pass_nx;
      fail_evt <= fail_nx;
    end
  end

  // clr takes priority over a same-edge increment
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if (clr) begin
      fail_cnt <= '0;
    end else if (fail_nx && (fail_cnt != CNT_MAX)) begin
      fail_cnt <= fail_cnt + 1'b1;
    end
  end

`ifdef GCLK_CHK_STICKY_EN
  logic fail_sticky;

  // A new failure beats a same-edge clr so no violation is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_sticky <= 1'b0;
    end else if (fail_nx) begin
      fail_sticky <= 1'b1;
    end else if (clr) begin
      fail_sticky <= 1'b0;
    end
  end

  assign fail = fail_sticky;
`else
  assign fail = fail_evt;
`endif

`ifndef SYNTHESIS
  a_verdict_exclusive: assert property (@(posedge clk) disable iff (rst) !(pass && fail_evt));
  a_wait_cnt_nonzero:  assert property (@(posedge clk) disable iff (rst) (state == WAIT) |-> (cnt != 8'd0));
`endif

endmodule

// File: tb/tb_gclk_change_checker.sv
// Self-checking bench for gclk_change_checker: WINDOW=4/CNT_W=8 and WINDOW=0/CNT_W=2 instances.
// A deadline-based model is compared every cycle; literal checks pin the directed scenarios.
module tb_gclk_change_checker;

  logic       clk = 1'b0;
  logic       rst, en_a, en_b, sig, resp, clr;
  logic       busy_a, pass_a, fail_a;
  logic       busy_b, pass_b, fail_b;
  logic [7:0] fail_cnt_a;
  logic [1:0] fail_cnt_b;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  checking    = 1'b0;

  always #5 clk = ~clk;

  gclk_change_checker #(.WINDOW(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .sig(sig), .resp(resp), .clr(clr),
    .busy(busy_a), .pass(pass_a), .fail(fail_a), .fail_cnt(fail_cnt_a)
  );

  gclk_change_checker #(.WINDOW(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .sig(sig), .resp(resp), .clr(clr),
    .busy(busy_b), .pass(pass_b), .fail(fail_b), .fail_cnt(fail_cnt_b)
  );

  // Model: an attempt at edge A with window W is pending until edge A+W
  int edge_no = 0;
  int m_win[2] = '{4, 0};
  int m_max[2] = '{255, 3};
  bit m_pend[2], m_pass[2], m_fail[2], m_valid[2], m_psig[2], m_presp[2];
  int m_deadline[2], m_cnt[2];

  always @(posedge clk) begin
    bit enk, chg, fall, vp, vf;
    for (int k = 0; k < 2; k++) begin
      enk = (k == 0) ? en_a : en_b;
      if (rst) begin
        m_pend[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_cnt[k] = 0;
        m_valid[k] = 0; m_psig[k] = 0; m_presp[k] = 0; m_deadline[k] = 0;
      end else begin
        chg  = m_valid[k] && (m_psig[k] != sig);
        fall = m_valid[k] && m_presp[k] && !resp;
        vp = 0;
        vf = 0;
        if (m_pend[k]) begin
          if (!enk) m_pend[k] = 0;
          else if (fall) begin vp = 1; m_pend[k] = 0; end
          else if (edge_no == m_deadline[k]) begin vf = 1; m_pend[k] = 0; end
        end else if (enk && chg) begin
          if (fall) vp = 1;
          else if (m_win[k] == 0) vf = 1;
          else begin m_pend[k] = 1; m_deadline[k] = edge_no + m_win[k]; end
        end
        if (clr) m_cnt[k] = 0;
        else if (vf && m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
        m_pass[k] = vp;
`ifdef GCLK_CHK_STICKY_EN
        m_fail[k] = vf ? 1'b1 : (clr ? 1'b0 : m_fail[k]);
`else
        m_fail[k] = vf;
`endif
        m_valid[k] = 1;
        m_psig[k]  = sig;
        m_presp[k] = resp;
      end
    end
    edge_no++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_busy_a", int'(busy_a), int'(m_pend[0]));
      checkOutput("model_pass_a", int'(pass_a), int'(m_pass[0]));
      checkOutput("model_fail_a", int'(fail_a), int'(m_fail[0]));
      checkOutput("model_cnt_a",  int'(fail_cnt_a), m_cnt[0]);
      checkOutput("model_busy_b", int'(busy_b), int'(m_pend[1]));
      checkOutput("model_pass_b", int'(pass_b), int'(m_pass[1]));
      checkOutput("model_fail_b", int'(fail_b), int'(m_fail[1]));
      checkOutput("model_cnt_b",  int'(fail_cnt_b), m_cnt[1]);
    end
  end

  // One clock edge per call; outputs are readable on return
  task automatic applyStimulus(input bit r, input bit ea, input bit eb,
                               input bit s, input bit rs, input bit c);
    @(negedge clk);
    rst = r; en_a = ea; en_b = eb; sig = s; resp = rs; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en_a = 0; en_b = 0; sig = 0; resp = 1; clr = 0;
    applyStimulus(1, 0, 0, 0, 1, 0);
    checking = 1'b1;
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkOutput("reset_busy_a", int'(busy_a), 0);
    checkOutput("reset_pass_a", int'(pass_a), 0);
    checkOutput("reset_fail_a", int'(fail_a), 0);
    checkOutput("reset_cnt_a",  int'(fail_cnt_a), 0);
    checkOutput("reset_cnt_b",  int'(fail_cnt_b), 0);

    // Pass within window: attempt, then fall two edges later
    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("attempt_busy", int'(busy_a), 1);
    checkOutput("attempt_nopass", int'(pass_a), 0);
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("wait_busy", int'(busy_a), 1);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("fall_pass", int'(pass_a), 1);
    checkOutput("fall_idle", int'(busy_a), 0);
    checkOutput("fall_cnt", int'(fail_cnt_a), 0);
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("pass_pulse_end", int'(pass_a), 0);

    // Timeout: fail exactly WINDOW edges after the attempt
    applyStimulus(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkOutput("timeout_pending", int'(fail_a), 0);
    end
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkOutput("timeout_fail", int'(fail_a), 1);
    checkOutput("timeout_cnt", int'(fail_cnt_a), 1);
    checkOutput("timeout_idle", int'(busy_a), 0);

    // Change inside WAIT ignored; change on the leaving edge ignored
    applyStimulus(0, 1, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkOutput("wait_chg_busy", int'(busy_a), 1);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("wait_chg_pass", int'(pass_a), 1);
    checkOutput("leave_chg_ignored", int'(busy_a), 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("after_leave_idle", int'(busy_a), 0);

    // Enable drop aborts with no verdict
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("abort_busy_pre", int'(busy_a), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("abort_busy", int'(busy_a), 0);
    checkOutput("abort_pass", int'(pass_a), 0);
    checkOutput("abort_cnt", int'(fail_cnt_a), 1);
    applyStimulus(0, 1, 0, 0, 1, 0);

    // Reset mid-WAIT, then a masked change on the release edge
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("rst_pre_busy", int'(busy_a), 1);
    applyStimulus(1, 1, 0, 1, 1, 0);
    checkOutput("rst_busy", int'(busy_a), 0);
    checkOutput("rst_cnt", int'(fail_cnt_a), 0);
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("release_masked", int'(busy_a), 0);
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("release_idle", int'(busy_a), 0);

    // WINDOW=0: overlapping pass, then failures to saturation
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("w0_pass", int'(pass_b), 1);
    checkOutput("w0_nofail", int'(fail_b), 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkOutput("w0_fail", int'(fail_b), 1);
    checkOutput("w0_cnt1", int'(fail_cnt_b), 1);
    applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkOutput("w0_saturate", int'(fail_cnt_b), 3);
    applyStimulus(0, 0, 1, 0, 1, 1);
    checkOutput("clr_wins_cnt", int'(fail_cnt_b), 0);
    checkOutput("clr_fail_same_edge", int'(fail_b), 1);
    applyStimulus(0, 0, 1, 0, 1, 0);
`ifdef GCLK_CHK_STICKY_EN
    checkOutput("sticky_hold", int'(fail_b), 1);
`else
    checkOutput("pulse_end", int'(fail_b), 0);
`endif
    applyStimulus(0, 0, 1, 0, 1, 1);
    checkOutput("clr_alone", int'(fail_b), 0);

    // Fall on the last window edge still passes
    applyStimulus(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("last_edge_pass", int'(pass_a), 1);
    checkOutput("last_edge_nofail", int'(fail_a), 0);
    applyStimulus(0, 1, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 1, 0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
